// File: rtl/io_channel_bank_pkg.sv
// Shared channel numbers, status bit positions and read-word helpers for the
// I/O channel bank and anything that decodes its channel selects.
package io_channel_bank_pkg;

   // Channel numbers as seen on the core's 3-bit select lines.
   typedef enum logic [2:0] {
      CH_SCRATCH = 3'd0,
      CH_DISP    = 3'd1,
      CH_KEY     = 3'd2,
      CH_TIMER   = 3'd3,
      CH_STATUS  = 3'd4,
      CH_GPO5    = 3'd5,
      CH_GPO6    = 3'd6,
      CH_GPO7    = 3'd7
   } chan_e;

   // Bit positions inside the status word.
   localparam int ST_KEY_AVAIL = 0;
   localparam int ST_DISP_DROP = 1;
   localparam int ST_TIMER_OVF = 2;

   localparam int WORD_W = 15;
   localparam int KEY_W  = 5;

   // Channel 2 read word: valid flag in the top bit, keycode in the bottom bits.
   // The keycode is forced to zero when nothing is queued so stale FIFO
   // contents never leak onto the bus.
   function automatic logic [WORD_W-1:0] pack_key_word(input logic avail,
                                                       input logic [KEY_W-1:0] code);
      logic [WORD_W-1:0] w;
      w = '0;
      w[WORD_W-1] = avail;
      w[KEY_W-1:0] = avail ? code : '0;
      return w;
   endfunction

   // Status word: sticky flags plus the live key-available bit.
   function automatic logic [WORD_W-1:0] pack_status(input logic timer_ovf,
                                                     input logic disp_drop,
                                                     input logic key_avail);
      logic [WORD_W-1:0] w;
      w = '0;
      w[ST_TIMER_OVF] = timer_ovf;
      w[ST_DISP_DROP] = disp_drop;
      w[ST_KEY_AVAIL] = key_avail;
      return w;
   endfunction

endpackage

// File: rtl/io_channel_bank_if.sv
// Core-side I/O channel bus: combinational read port plus a strobed write port.
interface io_channel_bank_if;
   import io_channel_bank_pkg::*;

   logic [2:0]        IO_read_sel;
   logic [WORD_W-1:0] IO_read_data;
   logic [2:0]        IO_write_sel;
   logic [WORD_W-1:0] IO_write_data;
   logic              IO_write_en;

   // The core drives selects and write data and consumes read data.
   modport master (
      output IO_read_sel,
      output IO_write_sel,
      output IO_write_data,
      output IO_write_en,
      input  IO_read_data
   );

   // The channel bank answers reads and applies writes.
   modport slave (
      input  IO_read_sel,
      input  IO_write_sel,
      input  IO_write_data,
      input  IO_write_en,
      output IO_read_data
   );

endinterface

// File: rtl/io_channel_bank_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers (mod 2*DEPTH) so full and
// empty are distinguishable without a separate counter register.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      rst_l,
   input  logic                      push,
   input  logic                      pop,
   input  logic [WIDTH-1:0]          din,
   output logic [WIDTH-1:0]          dout,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // A pop on an empty FIFO is a no-op. A push while full only lands when the
   // same cycle's pop frees the head slot; the caller decides whether to allow
   // that by gating push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Pointer and storage update; reset clears contents so dout reads zero.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_channel_bank.sv
// Responder for the core's I/O channels: scratch register, key and display
// FIFOs toward the DSKY, free-running timer, sticky status flags and three
// general-purpose output latches. Reads are combinational and side-effect
// free so the core can read speculatively.
module io_channel_bank
   import io_channel_bank_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TICK_DIV   = 1
) (
   input  logic                clock,
   input  logic                rst_l,
   io_channel_bank_if.slave    io,
   input  logic [KEY_W-1:0]    key_data,
   input  logic                key_valid,
   output logic                key_ready,
   output logic [WORD_W-1:0]   dsky_data,
   output logic                dsky_valid,
   input  logic                dsky_ready,
   output logic [WORD_W-1:0]   chan5_out,
   output logic [WORD_W-1:0]   chan6_out,
   output logic [WORD_W-1:0]   chan7_out
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [WORD_W-1:0] scratch;
   logic [WORD_W-1:0] timer;
   logic [PSW-1:0]    presc;
   logic              timer_ovf;
   logic              disp_drop;

   logic [KEY_W-1:0]  key_head;
   logic              key_full;
   logic              key_empty;
   logic [CW-1:0]     key_count;
   logic              key_push;
   logic              key_pop;

   logic              disp_full;
   logic              disp_empty;
   logic [CW-1:0]     disp_count;
   logic              disp_wr;
   logic              disp_pop;
   logic [3:0]        disp_free;

   logic              wr_scratch;
   logic              wr_timer;
   logic              wr_status;
   logic              wr_gpo5;
   logic              wr_gpo6;
   logic              wr_gpo7;

   logic              tick;
   logic              set_ovf;
   logic              set_drop;

   // Write strobes per channel.
   assign wr_scratch = io.IO_write_en && (io.IO_write_sel == CH_SCRATCH);
   assign disp_wr    = io.IO_write_en && (io.IO_write_sel == CH_DISP);
   assign key_pop    = io.IO_write_en && (io.IO_write_sel == CH_KEY);
   assign wr_timer   = io.IO_write_en && (io.IO_write_sel == CH_TIMER);
   assign wr_status  = io.IO_write_en && (io.IO_write_sel == CH_STATUS);
   assign wr_gpo5    = io.IO_write_en && (io.IO_write_sel == CH_GPO5);
   assign wr_gpo6    = io.IO_write_en && (io.IO_write_sel == CH_GPO6);
   assign wr_gpo7    = io.IO_write_en && (io.IO_write_sel == CH_GPO7);

   // Key side: ready depends only on full, so a same-cycle pop on a full FIFO
   // does not open the door for the DSKY that cycle.
   assign key_ready = !key_full;
   assign key_push  = key_valid && key_ready;

   // Display side: a core write on a full FIFO still lands if the DSKY takes
   // the head this cycle; otherwise the word is dropped and flagged.
   assign dsky_valid = !disp_empty;
   assign disp_pop   = dsky_valid && dsky_ready;
   assign set_drop   = disp_wr && disp_full && !dsky_ready;
   assign disp_free  = 4'(FIFO_DEPTH - int'(disp_count));

   sync_fifo #(
      .WIDTH (KEY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clock (clock),
      .rst_l (rst_l),
      .push  (key_push),
      .pop   (key_pop),
      .din   (key_data),
      .dout  (key_head),
      .full  (key_full),
      .empty (key_empty),
      .count (key_count)
   );

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_disp_fifo (
      .clock (clock),
      .rst_l (rst_l),
      .push  (disp_wr),
      .pop   (disp_pop),
      .din   (io.IO_write_data),
      .dout  (dsky_data),
      .full  (disp_full),
      .empty (disp_empty),
      .count (disp_count)
   );

   // A tick fires on the last prescaler count; a load overrides it entirely.
   assign tick    = (presc == PSW'(TICK_DIV - 1));
   assign set_ovf = tick && !wr_timer && (timer == {WORD_W{1'b1}});

   // Timer and prescaler: load restarts the prescaler, ticks wrap freely.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         timer <= '0;
         presc <= '0;
      end else if (wr_timer) begin
         timer <= io.IO_write_data;
         presc <= '0;
      end else if (tick) begin
         timer <= timer + 1'b1;
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         timer_ovf <= 1'b0;
         disp_drop <= 1'b0;
      end else begin
         if (set_ovf) begin
            timer_ovf <= 1'b1;
         end else if (wr_status && io.IO_write_data[ST_TIMER_OVF]) begin
            timer_ovf <= 1'b0;
         end
         if (set_drop) begin
            disp_drop <= 1'b1;
         end else if (wr_status && io.IO_write_data[ST_DISP_DROP]) begin
            disp_drop <= 1'b0;
         end
      end
   end

   // Scratch register and general-purpose output latches.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         scratch   <= '0;
         chan5_out <= '0;
         chan6_out <= '0;
         chan7_out <= '0;
      end else begin
         if (wr_scratch) scratch   <= io.IO_write_data;
         if (wr_gpo5)    chan5_out <= io.IO_write_data;
         if (wr_gpo6)    chan6_out <= io.IO_write_data;
         if (wr_gpo7)    chan7_out <= io.IO_write_data;
      end
   end

   // Combinational read mux; nothing here touches state.
   always_comb begin
      io.IO_read_data = '0;
      case (chan_e'(io.IO_read_sel))
         CH_SCRATCH: io.IO_read_data = scratch;
         CH_DISP:    io.IO_read_data = {11'b0, disp_free};
         CH_KEY:     io.IO_read_data = pack_key_word(!key_empty, key_head);
         CH_TIMER:   io.IO_read_data = timer;
         CH_STATUS:  io.IO_read_data = pack_status(timer_ovf, disp_drop, key_count != '0);
         CH_GPO5:    io.IO_read_data = chan5_out;
         CH_GPO6:    io.IO_read_data = chan6_out;
         CH_GPO7:    io.IO_read_data = chan7_out;
         default:    io.IO_read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_io_channel_bank.sv
// Bench for io_channel_bank: directed walk through the main behaviours, then
// randomized traffic against a queue-based reference model.
module tb_io_channel_bank;

   localparam int D  = 4;
   localparam int TD = 1;

   logic        clock;
   logic        rst_l;
   logic [4:0]  key_data;
   logic        key_valid;
   logic        key_ready;
   logic [14:0] dsky_data;
   logic        dsky_valid;
   logic        dsky_ready;
   logic [14:0] chan5_out;
   logic [14:0] chan6_out;
   logic [14:0] chan7_out;

   io_channel_bank_if bus ();

   io_channel_bank #(
      .FIFO_DEPTH (D),
      .TICK_DIV   (TD)
   ) dut (
      .clock      (clock),
      .rst_l      (rst_l),
      .io         (bus.slave),
      .key_data   (key_data),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .dsky_data  (dsky_data),
      .dsky_valid (dsky_valid),
      .dsky_ready (dsky_ready),
      .chan5_out  (chan5_out),
      .chan6_out  (chan6_out),
      .chan7_out  (chan7_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [4:0]  key_q [$];
   logic [14:0] disp_q [$];
   logic [14:0] m_scratch;
   logic [14:0] m_timer;
   logic [14:0] m_gpo [3];
   int          m_pc;
   logic        m_ovf;
   logic        m_drop;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      key_q.delete();
      disp_q.delete();
      m_scratch = '0;
      m_timer   = '0;
      m_gpo[0]  = '0;
      m_gpo[1]  = '0;
      m_gpo[2]  = '0;
      m_pc      = 0;
      m_ovf     = 1'b0;
      m_drop    = 1'b0;
   endtask

   function automatic logic [14:0] exp_read(input logic [2:0] sel);
      logic [14:0] r;
      r = '0;
      case (sel)
         3'd0: r = m_scratch;
         3'd1: r = 15'(D - disp_q.size());
         3'd2: if (key_q.size() > 0) r = 15'h4000 | 15'(key_q[0]);
         3'd3: r = m_timer;
         3'd4: r = {12'b0, m_ovf, m_drop, key_q.size() > 0};
         default: r = m_gpo[sel - 3'd5];
      endcase
      return r;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_update();
      logic        we;
      logic [2:0]  ws;
      logic [14:0] wd;
      logic        dpop;
      logic        sdrop;
      logic        sovf;
      we = bus.IO_write_en;
      ws = bus.IO_write_sel;
      wd = bus.IO_write_data;
      sdrop = 1'b0;
      sovf  = 1'b0;
      // Key FIFO: pop only if something is there, push only if not full beforehand.
      if (key_valid && key_q.size() < D) begin
         if (we && ws == 3'd2 && key_q.size() > 0) void'(key_q.pop_front());
         key_q.push_back(key_data);
      end else if (we && ws == 3'd2 && key_q.size() > 0) begin
         void'(key_q.pop_front());
      end
      // Display FIFO: DSKY pop frees a slot that a same-cycle write may use.
      dpop = dsky_ready && disp_q.size() > 0;
      if (dpop) void'(disp_q.pop_front());
      if (we && ws == 3'd1) begin
         if (disp_q.size() < D) disp_q.push_back(wd);
         else sdrop = 1'b1;
      end
      // Timer.
      if (we && ws == 3'd3) begin
         m_timer = wd;
         m_pc = 0;
      end else if (m_pc == TD - 1) begin
         m_pc = 0;
         if (m_timer == 15'h7FFF) sovf = 1'b1;
         m_timer = m_timer + 15'd1;
      end else begin
         m_pc++;
      end
      // Flags.
      if (we && ws == 3'd4) begin
         if (wd[2]) m_ovf = 1'b0;
         if (wd[1]) m_drop = 1'b0;
      end
      if (sovf)  m_ovf = 1'b1;
      if (sdrop) m_drop = 1'b1;
      if (we && ws == 3'd0) m_scratch = wd;
      if (we && ws >= 3'd5) m_gpo[ws - 3'd5] = wd;
   endtask

   // Check all outputs against the model, then clock once.
   task automatic step();
      #1;
      chk("rd_data", {17'b0, bus.IO_read_data}, {17'b0, exp_read(bus.IO_read_sel)});
      chk("key_ready", {31'b0, key_ready}, {31'b0, key_q.size() < D});
      chk("dsky_valid", {31'b0, dsky_valid}, {31'b0, disp_q.size() > 0});
      if (disp_q.size() > 0) chk("dsky_data", {17'b0, dsky_data}, {17'b0, disp_q[0]});
      chk("chan5", {17'b0, chan5_out}, {17'b0, m_gpo[0]});
      chk("chan6", {17'b0, chan6_out}, {17'b0, m_gpo[1]});
      chk("chan7", {17'b0, chan7_out}, {17'b0, m_gpo[2]});
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic peek(input string tag, input logic [2:0] sel, input logic [14:0] exp);
      bus.IO_read_sel = sel;
      #1;
      chk(tag, {17'b0, bus.IO_read_data}, {17'b0, exp});
   endtask

   task automatic idle();
      bus.IO_read_sel   = 3'd0;
      bus.IO_write_sel  = 3'd0;
      bus.IO_write_data = '0;
      bus.IO_write_en   = 1'b0;
      key_valid  = 1'b0;
      key_data   = '0;
      dsky_ready = 1'b0;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [14:0] data);
      bus.IO_write_en   = 1'b1;
      bus.IO_write_sel  = sel;
      bus.IO_write_data = data;
   endtask

   initial begin
      idle();
      model_reset();
      rst_l = 1'b0;
      #2;
      // Reset state of every channel and the handshake outputs.
      for (int s = 0; s < 8; s++) begin
         peek("rst_read", 3'(s), (s == 1) ? 15'd4 : 15'd0);
      end
      chk("rst_key_ready", {31'b0, key_ready}, 32'd1);
      chk("rst_dsky_valid", {31'b0, dsky_valid}, 32'd0);
      chk("rst_dsky_data", {17'b0, dsky_data}, 32'd0);
      @(negedge clock);
      rst_l = 1'b1;
      step();

      // Key FIFO push / peek / pop.
      key_valid = 1'b1;
      key_data  = 5'h11;
      step();
      key_data  = 5'h05;
      step();
      key_valid = 1'b0;
      peek("key_head1", 3'd2, 15'h4011);
      peek("key_avail1", 3'd4, 15'h0001);
      peek("key_head1_again", 3'd2, 15'h4011);
      wr(3'd2, 15'h7FFF);
      step();
      bus.IO_write_en = 1'b0;
      peek("key_head2", 3'd2, 15'h4005);
      wr(3'd2, 15'h0);
      step();
      bus.IO_write_en = 1'b0;
      peek("key_empty", 3'd2, 15'h0000);
      peek("key_avail0", 3'd4, 15'h0000);
      step();

      // Display FIFO overflow and drain.
      dsky_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr(3'd1, 15'h0100 + 15'(i));
         step();
      end
      bus.IO_write_en = 1'b0;
      peek("disp_free_full", 3'd1, 15'h0000);
      peek("disp_drop_set", 3'd4, 15'h0002);
      dsky_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_valid", {31'b0, dsky_valid}, 32'd1);
         chk("drain_data", {17'b0, dsky_data}, 32'h0100 + 32'(i));
         step();
      end
      chk("drain_done", {31'b0, dsky_valid}, 32'd0);
      dsky_ready = 1'b0;
      wr(3'd4, 15'h0002);
      step();
      bus.IO_write_en = 1'b0;
      peek("disp_drop_clr", 3'd4, 15'h0000);

      // Timer wrap and load-on-tick.
      wr(3'd3, 15'h7FFE);
      step();
      bus.IO_write_en = 1'b0;
      peek("timer_load", 3'd3, 15'h7FFE);
      step();
      peek("timer_7fff", 3'd3, 15'h7FFF);
      peek("ovf_not_yet", 3'd4, 15'h0000);
      step();
      peek("timer_wrap", 3'd3, 15'h0000);
      peek("ovf_set", 3'd4, 15'h0004);
      wr(3'd3, 15'h1234);
      step();
      bus.IO_write_en = 1'b0;
      peek("timer_load_tick", 3'd3, 15'h1234);
      wr(3'd4, 15'h0004);
      step();
      bus.IO_write_en = 1'b0;
      peek("ovf_clr", 3'd4, 15'h0000);

      // Key FIFO full: a pop does not raise key_ready in the same cycle.
      key_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         key_data = 5'(i + 1);
         step();
      end
      key_data = 5'h1F;
      wr(3'd2, 15'h0);
      #1;
      chk("full_pop_ready", {31'b0, key_ready}, 32'd0);
      step();
      bus.IO_write_en = 1'b0;
      #1;
      chk("after_pop_ready", {31'b0, key_ready}, 32'd1);
      step();
      key_valid = 1'b0;
      peek("full_again_head", 3'd2, 15'h4002);

      // Latch write, then asynchronous reset with FIFOs non-empty.
      wr(3'd6, 15'h1234);
      step();
      wr(3'd1, 15'h0ABC);
      step();
      idle();
      chk("chan6_set", {17'b0, chan6_out}, 32'h1234);
      #2;
      rst_l = 1'b0;
      #1;
      chk("arst_chan6", {17'b0, chan6_out}, 32'd0);
      chk("arst_dsky_valid", {31'b0, dsky_valid}, 32'd0);
      chk("arst_key_ready", {31'b0, key_ready}, 32'd1);
      peek("arst_key", 3'd2, 15'h0000);
      peek("arst_status", 3'd4, 15'h0000);
      model_reset();
      @(negedge clock);
      rst_l = 1'b1;
      step();

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         bus.IO_read_sel   = 3'($urandom_range(0, 7));
         bus.IO_write_en   = ($urandom_range(0, 2) == 0);
         bus.IO_write_sel  = 3'($urandom_range(0, 7));
         bus.IO_write_data = 15'($urandom);
         if (bus.IO_write_sel == 3'd3 && $urandom_range(0, 1) == 1)
            bus.IO_write_data = 15'h7FF0 | 15'($urandom_range(0, 15));
         key_valid  = ($urandom_range(0, 1) == 1);
         key_data   = 5'($urandom);
         dsky_ready = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
